// File: rtl/alu_mul_sequencer_pkg.sv
// Shared definitions for the shift-add multiply sequencer that borrows the EX-stage ALU.
package alu_mul_sequencer_pkg;

  localparam int         WIDTH_DEF = 32;
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [5:0] FUNC_NOP  = 6'h00;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_FIX,
    S_DONE
  } state_e;

endpackage

// File: rtl/alu_mul_sequencer.sv
// MULT/MULTU engine: runs WIDTH shift-add steps on the shared ALU, then fixes the sign of the product.
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] ex_in1,
  input  logic [WIDTH-1:0] ex_in2,
  input  logic [5:0]       ex_func,
  input  logic [1:0]       ex_aluop,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [5:0]       alu_func,
  output logic [1:0]       alu_aluop,
  input  logic [WIDTH-1:0] alu_result,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e           r_state;
  state_e           w_next_state;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_mcand;
  logic             r_neg;
  logic [CNT_W-1:0] r_count;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_addend;
  logic             w_carry;

  // Carry-out of an add recovered from the operand and sum MSBs, since the ALU exposes no carry.
  function automatic logic add_carry(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb & b_msb) | ((a_msb | b_msb) & ~s_msb);
  endfunction

  assign w_abs_a  = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
  assign w_abs_b  = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
  assign w_addend = r_lo[0] ? r_mcand : '0;
  assign w_carry  = add_carry(r_hi[WIDTH-1], w_addend[WIDTH-1], alu_result[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state elements use non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    w_next_state = r_state;
    alu_in1      = ex_in1;
    alu_in2      = ex_in2;
    alu_func     = ex_func;
    alu_aluop    = ex_aluop;
    stall        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        stall = start;
        if (start) w_next_state = S_BUSY;
      end
      S_BUSY: begin
        alu_in1   = r_hi;
        alu_in2   = w_addend;
        alu_func  = FUNC_NOP;
        alu_aluop = ALUOP_ADD;
        stall     = 1'b1;
        busy      = 1'b1;
        if (r_count == CNT_W'(WIDTH - 1)) w_next_state = S_FIX;
      end
      S_FIX: begin
        stall        = 1'b1;
        busy         = 1'b1;
        w_next_state = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_mcand <= '0;
      r_neg   <= 1'b0;
      r_count <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand <= w_abs_a;
            r_neg   <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            r_hi    <= '0;
            r_lo    <= w_abs_b;
            r_count <= '0;
          end
        end
        S_BUSY: begin
          {r_hi, r_lo} <= {w_carry, alu_result, r_lo[WIDTH-1:1]};
          r_count      <= r_count + 1'b1;
        end
        S_FIX: begin
          // Magnitudes were multiplied; restore the sign over the full double-width product.
          if (r_neg) {r_hi, r_lo} <= '0 - {r_hi, r_lo};
        end
        default: ;
      endcase
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural ALU closing the loop.
module tb_alu_mul_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         is_signed;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] ex_in1;
  logic [W-1:0] ex_in2;
  logic [5:0]   ex_func;
  logic [1:0]   ex_aluop;
  logic [W-1:0] alu_in1;
  logic [W-1:0] alu_in2;
  logic [5:0]   alu_func;
  logic [1:0]   alu_aluop;
  logic [W-1:0] alu_result;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Stand-in for the external ALU: add for aluOp 00 / func 00, subtract otherwise.
  always_comb begin
    alu_result = alu_in1 - alu_in2;
    if (alu_aluop == 2'b00 && alu_func == 6'h00) alu_result = alu_in1 + alu_in2;
  end

  alu_mul_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .is_signed  (is_signed),
    .op_a       (op_a),
    .op_b       (op_b),
    .ex_in1     (ex_in1),
    .ex_in2     (ex_in2),
    .ex_func    (ex_func),
    .ex_aluop   (ex_aluop),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_func   (alu_func),
    .alu_aluop  (alu_aluop),
    .alu_result (alu_result),
    .stall      (stall),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one multiply from an IDLE cycle and returns at the negedge of the DONE cycle.
  task automatic run_mul(input string tag, input logic sgn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                         input logic [W-1:0] exp_lo, input bit hold_start);
    int n;
    bit stall_ok;
    @(negedge clk);
    check({tag, "_done_idle"}, done, 1'b0);
    start = 1'b1; is_signed = sgn; op_a = a; op_b = b;
    #1 check({tag, "_stall_start"}, stall, 1'b1);
    @(posedge clk);
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678; is_signed = ~sgn;
    check({tag, "_busy_aluop"}, {busy, alu_aluop, alu_func}, {1'b1, 2'b00, 6'h00});
    n = 0;
    stall_ok = 1'b1;
    while (!done && n < 100) begin
      if (!stall) stall_ok = 1'b0;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check({tag, "_latency"}, n, 33);
    check({tag, "_stall_held"}, stall_ok, 1'b1);
    check({tag, "_done_flags"}, {stall, busy}, 2'b00);
    check({tag, "_product"}, {hi, lo}, {exp_hi, exp_lo});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
    ex_in1 = 32'd7; ex_in2 = 32'd9; ex_func = 6'h20; ex_aluop = 2'b10;
    #12;
    check("reset_state", {hi, lo, done, busy, stall}, '0);
    rst_n = 1'b1;

    @(negedge clk);
    check("pass_through", {alu_in1, alu_in2, alu_func, alu_aluop},
          {32'd7, 32'd9, 6'h20, 2'b10});
    check("idle_flags", {stall, busy, done}, 3'b000);

    run_mul("mulu_3x5", 1'b0, 32'd3, 32'd5, 32'h0, 32'h0000_000F, 1'b0);
    run_mul("mulu_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0);
    run_mul("mult_m3x5", 1'b1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_mul("mult_min", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
    run_mul("mult_neg_neg", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 32'h0, 32'd42, 1'b0);

    @(negedge clk);
    check("done_single_pulse", done, 1'b0);
    check("hold_after_done", {hi, lo}, 64'd42);

    // Hold start throughout: junk operands during the op must not be re-latched.
    run_mul("hold_start", 1'b0, 32'd1000, 32'd1000, 32'h0, 32'd1_000_000, 1'b1);
    run_mul("back_to_back", 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0, 1'b0);
    @(negedge clk);
    check("b2b_done_low", done, 1'b0);

    // Reset mid-operation.
    start = 1'b1; is_signed = 1'b0; op_a = 32'd3; op_b = 32'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_reset_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("reset_mid_hilo", {hi, lo}, 64'd0);
    check("reset_mid_flags", {busy, stall, done}, 3'b000);
    check("reset_mid_mux", {alu_in1, alu_in2, alu_func, alu_aluop},
          {32'd7, 32'd9, 6'h20, 2'b10});
    @(negedge clk);
    rst_n = 1'b1;
    run_mul("after_reset", 1'b0, 32'd2, 32'd2, 32'h0, 32'd4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
